// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame deframer: FSM state encoding,
// error codes, default start-of-frame byte and a width helper.
package uart_frame_pkg;

    // Deframer states; busy is decoded as "state != ST_IDLE".
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_PAY  = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Error codes reported on err_code alongside a frame_err pulse.
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Default start-of-frame marker.
    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

    // Address width for a buffer of 'depth' entries; never narrower than 1 bit
    // so a single-entry buffer still has a legal address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for uart_frame_rx: DEPTH x 8 bit, synchronous write and
// registered synchronous read. Reads beyond DEPTH-1 return 8'h00 so a host
// scanning a fixed address range never sees stale or undefined data.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // Depth expressed at address width + 1 so the range compare is exact
    // for non-power-of-two depths.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [7:0] mem [DEPTH];

    logic raddr_ok;
    assign raddr_ok = ({1'b0, raddr} < DEPTH_W);

    // Payload storage: written one byte per accepted payload strobe.
    // NOTE: the array has no reset on purpose -- contents are only meaningful
    // once a frame has been written, and a reset port would turn the RAM into
    // a bank of flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port: one cycle from raddr to rdata, zero out of range.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= 8'h00;
        end else if (raddr_ok) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= 8'h00;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: frame deframer fed by a byte-strobe serial receiver.
// Frame format: SOF, LEN (1..MAX_LEN), LEN payload bytes, checksum where
// checksum = LEN ^ payload[0] ^ ... ^ payload[LEN-1].
// A good frame is held in the payload buffer until the host pulses ack;
// a rejected frame produces a one-cycle frame_err with a held err_code.
// Optional inter-byte timeout is enabled by defining UART_FRAME_RX_TIMEOUT_EN;
// without it the deframer never times out and TIMEOUT_CYC is unused.
// MAX_LEN must lie in 1..255 since the length travels in one byte.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF         = SOF_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 120000,
    localparam int        AW          = addr_width(MAX_LEN),
    localparam int        LW          = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rcv,
    input  logic [7:0]    data,
    input  logic          ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_ok,
    output logic [LW-1:0] frame_len,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic          overrun,
    output logic          busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] cnt;
    logic [7:0]    csum;

    // Length byte is legal only in 1..MAX_LEN.
    logic len_bad;
    assign len_bad = (data == 8'd0) || (data > MAX_LEN_B);

    // The byte being stored now is the last payload byte of the frame.
    logic last_pay;
    assign last_pay = (cnt == (len - LW'(1)));

    // Buffer write: only payload bytes while collecting; frozen otherwise.
    logic buf_we;
    assign buf_we = (state == ST_PAY) && rcv;

    assign busy = (state != ST_IDLE);

    // Timeout request from the optional inter-byte timer.
    logic tmo_fire;

`ifdef UART_FRAME_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_active;

    // Only mid-frame states wait on the next byte; IDLE and DONE never time out.
    assign tmo_active = (state == ST_LEN) || (state == ST_PAY) || (state == ST_CHK);

    // A byte arriving in the expiry cycle is processed instead of timing out.
    assign tmo_fire = tmo_active && !rcv && (tmo_cnt == TMO_LAST);

    // Inter-byte timer: cleared by every byte and whenever no frame is open.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (rcv || !tmo_active || tmo_fire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    // Timeout not built: keep the parameter referenced and the request idle.
    localparam int unused_tmo_cyc = TIMEOUT_CYC;
    assign tmo_fire = 1'b0;
`endif

    // Deframer FSM with registered result pulses, length, checksum and overrun.
    // NOTE: every register here is assigned with <= so all next-state values
    // are computed from the same pre-edge snapshot; a blocking = would let a
    // later statement see an already-updated value and break the XOR chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            len       <= '0;
            cnt       <= '0;
            csum      <= 8'h00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_len <= '0;
            err_code  <= 2'd0;
            overrun   <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rcv && (data == SOF)) begin
                        state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (rcv) begin
                        if (len_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= ST_IDLE;
                        end else begin
                            len   <= data[LW-1:0];
                            cnt   <= '0;
                            csum  <= data;
                            state <= ST_PAY;
                        end
                    end
                end

                ST_PAY: begin
                    // SOF values inside the payload are ordinary data.
                    if (rcv) begin
                        csum <= csum ^ data;
                        cnt  <= cnt + LW'(1);
                        if (last_pay) begin
                            state <= ST_CHK;
                        end
                    end
                end

                ST_CHK: begin
                    if (rcv) begin
                        if (data == csum) begin
                            frame_ok  <= 1'b1;
                            frame_len <= len;
                            state     <= ST_DONE;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CSUM;
                            state     <= ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    // Buffer is frozen; ack releases it and its clear beats a
                    // simultaneous byte.
                    if (ack) begin
                        overrun <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (rcv) begin
                        overrun <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Timeout only fires mid-frame on a cycle with no byte, so it never
            // collides with a pulse or transition decided above.
            if (tmo_fire) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
                state     <= ST_IDLE;
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk   (clk),
        .rstn  (rstn),
        .we    (buf_we),
        .waddr (cnt[AW-1:0]),
        .wdata (data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx (MAX_LEN=16, TIMEOUT_CYC=50).
// Expected frame results are queued when a frame is sent; a monitor queues
// observed frame_ok/frame_err pulses and each test pops and compares them.
// Build with UART_FRAME_RX_TIMEOUT_EN to exercise the timeout path.
module tb_uart_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 50;
    localparam int AW      = 4;
    localparam int LW      = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rcv = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          frame_ok;
    logic [LW-1:0] frame_len;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          overrun;
    logic          busy;

    uart_frame_rx #(
        .SOF         (8'h7E),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rcv       (rcv),
        .data      (data),
        .ack       (ack),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .frame_ok  (frame_ok),
        .frame_len (frame_len),
        .frame_err (frame_err),
        .err_code  (err_code),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ok;
        logic [LW-1:0] len;
        logic [1:0]    code;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] pay[$];
    logic [7:0] held[$];
    logic [LW-1:0] last_len = '0;
    int         checks = 0;
    int         errors = 0;
    logic       prev_ok = 1'b0;
    logic       prev_err = 1'b0;

    // Monitor: record result pulses, check exclusivity and single-cycle width.
    always @(negedge clk) begin
        ev_t ev;
        if (frame_ok || frame_err) begin
            checks++;
            if ((frame_ok && frame_err) || (frame_ok && prev_ok) || (frame_err && prev_err)) begin
                errors++;
                $display("FAIL pulse_shape: ok=%b err=%b prev_ok=%b prev_err=%b, required one 1-cycle pulse",
                         frame_ok, frame_err, prev_ok, prev_err);
            end
            ev.ok   = frame_ok;
            ev.len  = frame_ok ? frame_len : '0;
            ev.code = frame_ok ? 2'd0 : err_code;
            obs_q.push_back(ev);
        end
        prev_ok  = frame_ok;
        prev_err = frame_err;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rcv  = 1'b1;
        data = b;
        @(negedge clk);
        rcv  = 1'b0;
        data = 8'h00;
    endtask

    // Send SOF, length, pay[] and checksum^corrupt; queue the expected result.
    task automatic send_frame(input logic [7:0] corrupt);
        logic [7:0] cs;
        ev_t ev;
        cs = 8'(pay.size());
        foreach (pay[i]) cs = cs ^ pay[i];
        send_byte(8'h7E);
        send_byte(8'(pay.size()));
        foreach (pay[i]) send_byte(pay[i]);
        if (corrupt == 8'h00) begin
            ev.ok = 1'b1; ev.len = LW'(pay.size()); ev.code = 2'd0;
            held = pay;
            last_len = LW'(pay.size());
        end else begin
            ev.ok = 1'b0; ev.len = '0; ev.code = 2'd2;
        end
        exp_q.push_back(ev);
        send_byte(cs ^ corrupt);
    endtask

    // Wait (bounded) for an observed pulse and pop it with its expectation.
    task automatic drain_one(output ev_t e, output ev_t o, output bit got);
        got = 1'b0;
        e = '0;
        o = '0;
        for (int n = 0; n < 64; n++) begin
            if (obs_q.size() != 0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) o = obs_q.pop_front();
        if (exp_q.size() != 0) e = exp_q.pop_front();
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_data, frame_ok, frame_len, frame_err, err_code, overrun, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%h ok=%b len=%0d err=%b code=%0d ovr=%b busy=%b, required all 0",
                     rd_data, frame_ok, frame_len, frame_err, err_code, overrun, busy);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        ev_t e, o;
        bit got;
        pay = {8'h11, 8'h22, 8'h33};
        send_frame(8'h00);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL good_frame_event: got=%b ok=%b len=%0d code=%0d, required ok=%b len=%0d code=%0d",
                     got, o.ok, o.len, o.code, e.ok, e.len, e.code);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL good_frame_busy: busy=%b, required 1", busy);
        end
        for (int i = 0; i < held.size(); i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            checks++;
            if (rd_data !== held[i]) begin
                errors++;
                $display("FAIL good_frame_rd[%0d]: rd_data=%h, required %h", i, rd_data, held[i]);
            end
        end
        do_ack();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL good_frame_ack_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_bad_checksum();
        ev_t e, o;
        bit got;
        pay = {8'hAA, 8'h55};
        send_frame(8'hFD);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL bad_csum_event: got=%b ok=%b len=%0d code=%0d, required ok=%b len=%0d code=%0d",
                     got, o.ok, o.len, o.code, e.ok, e.len, e.code);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err_code !== 2'd2 || frame_len !== last_len) begin
            errors++;
            $display("FAIL bad_csum_state: busy=%b code=%0d len=%0d, required busy=0 code=2 len=%0d",
                     busy, err_code, frame_len, last_len);
        end
    endtask

    task automatic test_bad_length();
        ev_t e, o;
        bit got;
        logic [7:0] bad_lens[2];
        bad_lens[0] = 8'h00;
        bad_lens[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            e.ok = 1'b0; e.len = '0; e.code = 2'd1;
            exp_q.push_back(e);
            send_byte(8'h7E);
            send_byte(bad_lens[k]);
            drain_one(e, o, got);
            checks++;
            if (!got || o !== e) begin
                errors++;
                $display("FAIL bad_len_%h: got=%b ok=%b code=%0d, required ok=0 code=1",
                         bad_lens[k], got, o.ok, o.code);
            end
        end
        pay = {8'hC4};
        send_frame(8'h00);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL bad_len_recover: got=%b ok=%b len=%0d, required ok=1 len=%0d",
                     got, o.ok, o.len, e.len);
        end
        do_ack();
    endtask

    task automatic test_max_len_sof_payload();
        ev_t e, o;
        bit got;
        pay = {};
        for (int i = 0; i < MAX_LEN; i++) begin
            pay.push_back((i == 3 || i == 4) ? 8'h7E : 8'($urandom_range(0, 255)));
        end
        send_frame(8'h00);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL max_len_event: got=%b ok=%b len=%0d code=%0d, required ok=1 len=%0d",
                     got, o.ok, o.len, o.code, e.len);
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            checks++;
            if (rd_data !== held[i]) begin
                errors++;
                $display("FAIL max_len_rd[%0d]: rd_data=%h, required %h", i, rd_data, held[i]);
            end
        end
        do_ack();
    endtask

    task automatic test_overrun();
        ev_t e, o;
        bit got;
        pay = {8'hC3, 8'h3C};
        send_frame(8'h00);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL overrun_frame: got=%b ok=%b len=%0d, required ok=1 len=2", got, o.ok, o.len);
        end
        send_byte(8'h41);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1 || obs_q.size() != 0 || frame_len !== 5'd2) begin
            errors++;
            $display("FAIL overrun_set: ovr=%b busy=%b extra=%0d len=%0d, required ovr=1 busy=1 extra=0 len=2",
                     overrun, busy, obs_q.size(), frame_len);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            checks++;
            if (rd_data !== held[i]) begin
                errors++;
                $display("FAIL overrun_buf[%0d]: rd_data=%h, required %h", i, rd_data, held[i]);
            end
        end
        do_ack();
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ack: ovr=%b busy=%b, required 0 0", overrun, busy);
        end
    endtask

    task automatic test_ack_rcv_same_cycle();
        ev_t e, o;
        bit got;
        pay = {8'h99};
        send_frame(8'h00);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL ack_rcv_frame: got=%b ok=%b len=%0d, required ok=1 len=1", got, o.ok, o.len);
        end
        @(negedge clk);
        rcv = 1'b1; data = 8'h41; ack = 1'b1;
        @(negedge clk);
        rcv = 1'b0; data = 8'h00; ack = 1'b0;
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_rcv_same: ovr=%b busy=%b, required 0 0", overrun, busy);
        end
    endtask

`ifdef UART_FRAME_RX_TIMEOUT_EN
    task automatic test_timeout();
        ev_t e, o;
        bit got;
        int n;
        e.ok = 1'b0; e.len = '0; e.code = 2'd3;
        exp_q.push_back(e);
        send_byte(8'h7E);
        send_byte(8'h02);
        send_byte(8'hAA);
        n = 0;
        for (int k = 1; k <= 4 * TMO; k++) begin
            @(negedge clk);
            if (frame_err) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_cycle: pulse at idle cycle %0d, required %0d", n, TMO);
        end
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_event: got=%b ok=%b code=%0d busy=%b, required ok=0 code=3 busy=0",
                     got, o.ok, o.code, busy);
        end
    endtask
`else
    task automatic test_no_timeout();
        ev_t e, o;
        bit got;
        send_byte(8'h7E);
        send_byte(8'h02);
        send_byte(8'hAA);
        repeat (4 * TMO) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL no_timeout_busy: busy=%b pulses=%0d, required busy=1 pulses=0", busy, obs_q.size());
        end
        e.ok = 1'b1; e.len = 5'd2; e.code = 2'd0;
        exp_q.push_back(e);
        held = {8'hAA, 8'hBB};
        last_len = 5'd2;
        send_byte(8'hBB);
        send_byte(8'h02 ^ 8'hAA ^ 8'hBB);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL no_timeout_finish: got=%b ok=%b len=%0d, required ok=1 len=2", got, o.ok, o.len);
        end
        do_ack();
    endtask
`endif

    task automatic test_reset_mid_frame();
        ev_t e, o;
        bit got;
        send_byte(8'h7E);
        send_byte(8'h03);
        send_byte(8'h11);
        @(negedge clk);
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_frame: busy=%b ok=%b err=%b pulses=%0d, required all 0",
                     busy, frame_ok, frame_err, obs_q.size());
        end
        rstn = 1'b1;
        @(negedge clk);
        pay = {8'h5A};
        send_frame(8'h00);
        drain_one(e, o, got);
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL reset_recover_event: got=%b ok=%b len=%0d, required ok=1 len=1", got, o.ok, o.len);
        end
        @(negedge clk);
        rd_addr = '0;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h5A) begin
            errors++;
            $display("FAIL reset_recover_rd: rd_data=%h, required 5a", rd_data);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_max_len_sof_payload();
        test_overrun();
        test_ack_rcv_same_cycle();
`ifdef UART_FRAME_RX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed left=%0d expected left=%0d, required 0 0",
                     obs_q.size(), exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
